result_sram_drain: RTL and testbench

//  Read-side counterpart of the result SRAM write path. The array writes one

---
 rtl/result_sram_drain_if.sv | 30 +++
 rtl/result_sram_drain.sv | 133 +++++++++++++
 tb/tb_result_sram_drain.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_sram_drain_if.sv
// Output beat stream of the result SRAM drain: one partial sum per beat plus
// end-of-row / end-of-job markers.
interface result_sram_drain_if #(
    parameter int PARTIAL_SUM_BW = 24
);
    // A beat transfers on a rising clk edge where out_valid && out_ready. Once
    // out_valid rises, out_data/out_eor/out_last stay stable and out_valid stays
    // high until that transfer; out_valid never depends on out_ready.
    logic                      out_valid;
    logic                      out_ready;
    logic [PARTIAL_SUM_BW-1:0] out_data;
    logic                      out_eor;
    logic                      out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_eor,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_eor,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/result_sram_drain.sv
// Reads result rows back from the result SRAM and streams each row out one
// partial sum per beat, column 0 first.
module result_sram_drain #(
    parameter int ADDRESSSIZE    = 10,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int MATRIX_SIZE    = 16,
    parameter int ROWCNT_BW      = 5
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   start,
    input  logic [ADDRESSSIZE-1:0]                 base_addr,
    input  logic [ROWCNT_BW-1:0]                   num_rows,
    output logic                                   sram_rd_en,
    output logic [ADDRESSSIZE-1:0]                 sram_rd_addr,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  sram_rd_data,
    result_sram_drain_if.master                    out_if,
    output logic                                   busy,
    output logic                                   done,
    output logic [2:0]                             dbg_state
);

    localparam int ROW_BW = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam int COL_BW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_CAP    = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    localparam logic [COL_BW-1:0]    COL_LAST = COL_BW'(MATRIX_SIZE - 1);
    localparam logic [ROWCNT_BW-1:0] ROW_ONE  = ROWCNT_BW'(1);

    logic [2:0]             state_q,     state_d;
    logic [ADDRESSSIZE-1:0] addr_q,      addr_d;
    logic [ROWCNT_BW-1:0]   rows_left_q, rows_left_d;
    logic [COL_BW-1:0]      col_q,       col_d;
    logic [ROW_BW-1:0]      row_q,       row_d;

    logic stream;
    logic beat_eor;

    assign stream   = (state_q == S_STREAM);
    assign beat_eor = stream && (col_q == COL_LAST);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rows_left_d = rows_left_q;
        col_d       = col_q;
        row_d       = row_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    rows_left_d = num_rows;
                    state_d     = (num_rows == '0) ? S_FIN : S_RD;
                end
            end

            S_RD: begin
                state_d = S_CAP;
            end

            // Read data arrives one cycle after the strobe, so it is captured here.
            S_CAP: begin
                row_d   = sram_rd_data;
                col_d   = '0;
                state_d = S_STREAM;
            end

            S_STREAM: begin
                if (out_if.out_ready) begin
                    // Shift so the next column always sits in the low bits.
                    row_d = row_q >> PARTIAL_SUM_BW;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (rows_left_q > ROW_ONE) begin
                            rows_left_d = rows_left_q - ROW_ONE;
                            addr_d      = addr_q + ADDRESSSIZE'(1);
                            state_d     = S_RD;
                        end else begin
                            rows_left_d = '0;
                            state_d     = S_FIN;
                        end
                    end else begin
                        col_d = col_q + COL_BW'(1);
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rows_left_q <= '0;
            col_q       <= '0;
            row_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rows_left_q <= rows_left_d;
            col_q       <= col_d;
            row_q       <= row_d;
        end
    end

    // All outputs are decoded from registered state only.
    assign sram_rd_en   = (state_q == S_RD);
    assign sram_rd_addr = sram_rd_en ? addr_q : '0;

    assign out_if.out_valid = stream;
    assign out_if.out_data  = stream ? row_q[PARTIAL_SUM_BW-1:0] : '0;
    assign out_if.out_eor   = beat_eor;
    assign out_if.out_last  = beat_eor && (rows_left_q == ROW_ONE);

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_result_sram_drain.sv
// Randomized bench for result_sram_drain: SRAM model, per-job expected beat /
// address / done queues, a negedge compare process and a final report.
module tb_result_sram_drain;

    localparam int AW  = 10;
    localparam int PSB = 24;
    localparam int MS  = 16;
    localparam int RB  = 5;
    localparam int RW  = PSB * MS;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [RB-1:0] num_rows;
    logic          sram_rd_en;
    logic [AW-1:0] sram_rd_addr;
    logic [RW-1:0] sram_rd_data;
    logic          busy;
    logic          done;
    logic [2:0]    dbg_state;

    result_sram_drain_if #(.PARTIAL_SUM_BW(PSB)) out_if ();

    result_sram_drain #(
        .ADDRESSSIZE(AW), .PARTIAL_SUM_BW(PSB), .MATRIX_SIZE(MS), .ROWCNT_BW(RB)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
        .sram_rd_data(sram_rd_data), .out_if(out_if), .busy(busy), .done(done),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM model ----------------
    logic [RW-1:0] mem [0:(1<<AW)-1];

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Garbage on the bus whenever no read was issued the cycle before.
    always @(posedge clk) begin
        if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
        else            sram_rd_data <= rand_row();
    end

    // ---------------- ready driver ----------------
    int unsigned ready_pct = 100;
    always @(posedge clk) begin
        #1;
        out_if.out_ready = ($urandom_range(99) < ready_pct);
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    logic [PSB+1:0] exp_q[$];      // {last, eor, data}
    logic [AW-1:0]  exp_addr_q[$];
    int             exp_done_q[$]; // expected done cycle, -1 = untimed
    logic [PSB-1:0] obs_data[$];
    logic [AW-1:0]  obs_addr[$];
    int             rd_cnt   = 0;
    int             done_cnt = 0;
    int             done_cyc = 0;
    bit             prev_stall = 0;
    logic [PSB+1:0] head;
    int             ed;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 0;
        end else begin
            if (sram_rd_en) begin
                rd_cnt++;
                obs_addr.push_back(sram_rd_addr);
                if (exp_addr_q.size() == 0) chk("rd_unexpected", 64'(sram_rd_addr), 64'hffff);
                else chk("rd_addr", 64'(sram_rd_addr), 64'(exp_addr_q.pop_front()));
            end
            if (prev_stall) chk("valid_held", 64'(out_if.out_valid), 64'd1);
            if (out_if.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", 64'(out_if.out_data), 64'hffff_ffff);
                end else begin
                    head = exp_q[0];
                    chk("beat_data", 64'(out_if.out_data), 64'(head[PSB-1:0]));
                    chk("beat_eor",  64'(out_if.out_eor),  64'(head[PSB]));
                    chk("beat_last", 64'(out_if.out_last), 64'(head[PSB+1]));
                    if (out_if.out_ready) begin
                        void'(exp_q.pop_front());
                        obs_data.push_back(out_if.out_data);
                    end
                end
            end
            prev_stall = out_if.out_valid && !out_if.out_ready;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_done_q.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    ed = exp_done_q.pop_front();
                    if (ed >= 0) chk("done_cycle", 64'(cyc), 64'(ed));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issues one job, loads the model with its expected reads and beats, and
    // optionally waits for done. acc is the cycle number of the accepting edge.
    task automatic run_job(input logic [AW-1:0] b, input int n, input bit timed,
                           input bit poke, input bit wait_done, output int acc);
        int            budget;
        int            d0;
        logic [AW-1:0] a;
        logic [RW-1:0] row;
        budget = 0;
        @(posedge clk); #1;
        while (busy !== 1'b0 && budget < 5000) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 5000) chk("idle_timeout", 64'(budget), 64'd0);
        obs_data.delete();
        obs_addr.delete();
        rd_cnt = 0;
        d0     = done_cnt;
        for (int r = 0; r < n; r++) begin
            a   = b + AW'(r);
            row = mem[a];
            exp_addr_q.push_back(a);
            for (int k = 0; k < MS; k++)
                exp_q.push_back({(k == MS-1) && (r == n-1), (k == MS-1), row[k*PSB +: PSB]});
        end
        start     = 1'b1;
        base_addr = b;
        num_rows  = RB'(n);
        @(posedge clk); #1;
        acc = cyc;
        exp_done_q.push_back(timed ? acc + n * (MS + 2) : -1);
        start     = 1'b0;
        base_addr = AW'($urandom());
        num_rows  = RB'($urandom());
        chk("busy_after_accept", 64'(busy), 64'd1);
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            start = 1'b1; base_addr = 100; num_rows = 5;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (wait_done) begin
            budget = 0;
            while (done_cnt == d0 && budget < 20000) begin
                @(negedge clk);
                budget++;
            end
            if (done_cnt == d0) chk("done_timeout", 64'(budget), 64'd0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rd_en"},   64'(sram_rd_en),       64'd0);
        chk({tag, "_rd_addr"}, 64'(sram_rd_addr),     64'd0);
        chk({tag, "_valid"},   64'(out_if.out_valid), 64'd0);
        chk({tag, "_data"},    64'(out_if.out_data),  64'd0);
        chk({tag, "_eor"},     64'(out_if.out_eor),   64'd0);
        chk({tag, "_last"},    64'(out_if.out_last),  64'd0);
        chk({tag, "_busy"},    64'(busy),             64'd0);
        chk({tag, "_done"},    64'(done),             64'd0);
        chk({tag, "_state"},   64'(dbg_state),        64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int            acc;
        int            n;
        int            d_before;
        logic [RW-1:0] row;
        int            wrap_exp [4] = '{1022, 1023, 0, 1};
        logic [AW-1:0] rb;

        rstn = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0;
        out_if.out_ready = 1'b1;
        sram_rd_data = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = rand_row();
        for (int k = 0; k < MS; k++) row[k*PSB +: PSB] = PSB'(k - 8);
        mem[3] = row;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rstn = 1'b1;

        // single row, values -8..7
        run_job(10'd3, 1, 1, 0, 1, acc);
        chk("t2_beats", 64'(obs_data.size()), 64'd16);
        if (obs_data.size() == 16) begin
            chk("t2_first", 64'(obs_data[0]),  64'h00ff_fff8);
            chk("t2_lastb", 64'(obs_data[15]), 64'h0000_0007);
        end
        chk("t2_done_lat", 64'(done_cyc - acc), 64'd18);

        // full 16-row job
        run_job(10'd0, 16, 1, 0, 1, acc);
        chk("t3_beats", 64'(obs_data.size()), 64'd256);
        chk("t3_reads", 64'(rd_cnt), 64'd16);
        chk("t3_done_lat", 64'(done_cyc - acc), 64'd288);

        // same job under backpressure
        ready_pct = 30;
        run_job(10'd0, 16, 0, 0, 1, acc);
        chk("t4_beats", 64'(obs_data.size()), 64'd256);
        chk("t4_reads", 64'(rd_cnt), 64'd16);
        ready_pct = 100;

        // address wrap
        run_job(10'd1022, 4, 1, 0, 1, acc);
        chk("t5_reads", 64'(obs_addr.size()), 64'd4);
        if (obs_addr.size() == 4)
            for (int i = 0; i < 4; i++) chk("t5_addr", 64'(obs_addr[i]), 64'(wrap_exp[i]));

        // zero-row job
        run_job(10'd50, 0, 1, 0, 1, acc);
        chk("t6_reads", 64'(rd_cnt), 64'd0);
        chk("t6_beats", 64'(obs_data.size()), 64'd0);
        chk("t6_done_lat", 64'(done_cyc - acc), 64'd0);

        // start pulsed while busy is ignored
        d_before = done_cnt;
        run_job(10'd7, 2, 1, 1, 1, acc);
        repeat (60) @(posedge clk);
        #1;
        chk("t6_one_done", 64'(done_cnt - d_before), 64'd1);
        chk("t6_poke_reads", 64'(rd_cnt), 64'd2);

        // random jobs with random backpressure
        for (int j = 0; j < 6; j++) begin
            ready_pct = (j % 2 == 0) ? 100 : $urandom_range(20, 90);
            n  = $urandom_range(0, 5);
            rb = AW'($urandom());
            run_job(rb, n, ready_pct == 100, 0, 1, acc);
            chk("rand_beats", 64'(obs_data.size()), 64'(n * MS));
            chk("rand_reads", 64'(rd_cnt), 64'(n));
        end
        ready_pct = 100;

        // reset in the middle of streaming
        run_job(10'd20, 3, 1, 0, 0, acc);
        repeat (8) @(posedge clk);
        #1;
        chk("t1_streaming", 64'(out_if.out_valid), 64'd1);
        d_before = done_cnt;
        rstn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_idle_outputs("t1");
        exp_q.delete();
        exp_addr_q.delete();
        exp_done_q.delete();
        rstn = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("t1_no_done", 64'(done_cnt - d_before), 64'd0);
        chk("t1_idle_state", 64'(dbg_state), 64'd0);

        // recovery after reset
        run_job(10'd3, 1, 1, 0, 1, acc);
        chk("post_reset_beats", 64'(obs_data.size()), 64'd16);
        repeat (4) @(posedge clk);
        #1;
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("exp_addr_drained", 64'(exp_addr_q.size()), 64'd0);
        chk("exp_done_drained", 64'(exp_done_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends on its own.
    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=%0d expected=finished", cyc);
        $fatal(1, "global timeout");
    end

endmodule
